// File: rtl/bus_ctrl_pkg.sv
// Shared types and defaults for the 68000 bus-control path
// (address decoder, DTACK generator, bus monitor).
package bus_ctrl_pkg;

  localparam int REGION_W = 3;

  typedef enum logic [REGION_W-1:0] {
    REG_NONE,
    REG_ROM,
    REG_RAM,
    REG_IO,
    REG_DRAM,
    REG_CAN,
    REG_OFFB
  } region_t;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    EXTWAIT,
    ACK,
    BERR
  } bus_state_t;

  localparam int unsigned DEFAULT_ROM_WAIT = 1;
  localparam int unsigned DEFAULT_RAM_WAIT = 0;
  localparam int unsigned DEFAULT_IO_WAIT  = 2;
  localparam int unsigned DEFAULT_TIMEOUT  = 255;
  localparam int unsigned DEFAULT_CNT_W    = 8;

endpackage

// File: rtl/region_priority_encoder.sv
// Collapses the decoder's one-hot-ish chip selects into a single region code.
// Fixed priority: ROM > RAM > IO > DRAM > CAN > OFFBOARD > NONE.
module region_priority_encoder
  import bus_ctrl_pkg::*;
(
  input  logic                romSelect,
  input  logic                ramSelect,
  input  logic                ioSelect,
  input  logic                dramSelect,
  input  logic                canSelect,
  input  logic                offBoardSelect,
  output logic [REGION_W-1:0] regionCode
);

  always_comb begin
    regionCode = REG_NONE;
    if (romSelect)           regionCode = REG_ROM;
    else if (ramSelect)      regionCode = REG_RAM;
    else if (ioSelect)       regionCode = REG_IO;
    else if (dramSelect)     regionCode = REG_DRAM;
    else if (canSelect)      regionCode = REG_CAN;
    else if (offBoardSelect) regionCode = REG_OFFB;
  end

endmodule

// File: rtl/bus_dtack_generator.sv
// Generates registered DTACK_L (fixed wait states or passed-through external ack)
// and BERR_L on timeout for the 68000 bus cycle.
module bus_dtack_generator
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned ROM_WAIT = DEFAULT_ROM_WAIT,
  parameter int unsigned RAM_WAIT = DEFAULT_RAM_WAIT,
  parameter int unsigned IO_WAIT  = DEFAULT_IO_WAIT,
  parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W    = DEFAULT_CNT_W
)
(
  input  logic Clock,
  input  logic Reset_H,
  input  logic AS_L,
  input  logic UDS_L,
  input  logic LDS_L,
  input  logic OnChipRomSelect_H,
  input  logic OnChipRamSelect_H,
  input  logic IOSelect_H,
  input  logic DramSelect_H,
  input  logic CanBusSelect_H,
  input  logic OffBoardMemory_H,
  input  logic DramDtack_L,
  input  logic CanBusDtack_L,
  input  logic OffBoardDtack_L,
  output logic DtackOut_L,
  output logic BusError_L
);

  localparam logic [CNT_W-1:0] ROM_LOAD    = CNT_W'(ROM_WAIT);
  localparam logic [CNT_W-1:0] RAM_LOAD    = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] IO_LOAD     = CNT_W'(IO_WAIT);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [REGION_W-1:0] decodedCode;
  region_t             decodedRegion;

  bus_state_t          stateReg, stateNext;
  region_t             regionReg, regionNext;
  logic [CNT_W-1:0]    waitCntReg, waitCntNext;
  logic [CNT_W-1:0]    timerReg, timerNext;
  logic                ackSyncReg, ackSyncNext;
  logic                dtackReg, dtackNext;
  logic                berrReg, berrNext;

  logic                cycleStart;
  logic                selectedAck;
  logic                timedOut;

  region_priority_encoder u_encoder (
    .romSelect      (OnChipRomSelect_H),
    .ramSelect      (OnChipRamSelect_H),
    .ioSelect       (IOSelect_H),
    .dramSelect     (DramSelect_H),
    .canSelect      (CanBusSelect_H),
    .offBoardSelect (OffBoardMemory_H),
    .regionCode     (decodedCode)
  );

  assign decodedRegion = region_t'(decodedCode);
  assign cycleStart    = !AS_L && (!UDS_L || !LDS_L);
  // timerReg holds the number of edges elapsed since edge 0
  assign timedOut      = (timerReg == TIMEOUT_CNT);

  always_comb begin
    selectedAck = 1'b1;
    case (regionReg)
      REG_DRAM: selectedAck = DramDtack_L;
      REG_CAN:  selectedAck = CanBusDtack_L;
      REG_OFFB: selectedAck = OffBoardDtack_L;
      default:  selectedAck = 1'b1;
    endcase
  end

  always_comb begin
    stateNext   = stateReg;
    regionNext  = regionReg;
    waitCntNext = waitCntReg;
    timerNext   = timerReg;
    ackSyncNext = 1'b1;
    dtackNext   = dtackReg;
    berrNext    = berrReg;

    case (stateReg)
      IDLE: begin
        dtackNext = 1'b1;
        berrNext  = 1'b1;
        if (cycleStart) begin
          regionNext  = decodedRegion;
          timerNext   = CNT_ONE;
          waitCntNext = '0;
          case (decodedRegion)
            REG_ROM: begin waitCntNext = ROM_LOAD; stateNext = COUNT; end
            REG_RAM: begin waitCntNext = RAM_LOAD; stateNext = COUNT; end
            REG_IO:  begin waitCntNext = IO_LOAD;  stateNext = COUNT; end
            default: stateNext = EXTWAIT;
          endcase
        end
      end

      COUNT: begin
        if (AS_L) begin
          stateNext = IDLE;
        end else if (waitCntReg == '0) begin
          dtackNext = 1'b0;
          stateNext = ACK;
        end else if (timedOut) begin
          berrNext  = 1'b0;
          stateNext = BERR;
        end else begin
          waitCntNext = waitCntReg - CNT_ONE;
          timerNext   = timerReg + CNT_ONE;
        end
      end

      EXTWAIT: begin
        // External ack is registered once before use, so the ack tested here
        // is the one sampled on the previous edge; ack beats timeout.
        if (AS_L) begin
          stateNext = IDLE;
        end else if (!ackSyncReg) begin
          dtackNext = 1'b0;
          stateNext = ACK;
        end else if (timedOut) begin
          berrNext  = 1'b0;
          stateNext = BERR;
        end else begin
          timerNext   = timerReg + CNT_ONE;
          ackSyncNext = selectedAck;
        end
      end

      ACK: begin
        if (AS_L) begin
          dtackNext = 1'b1;
          stateNext = IDLE;
        end
      end

      BERR: begin
        if (AS_L) begin
          berrNext  = 1'b1;
          stateNext = IDLE;
        end
      end

      default: begin
        dtackNext = 1'b1;
        berrNext  = 1'b1;
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      stateReg   <= IDLE;
      regionReg  <= REG_NONE;
      waitCntReg <= '0;
      timerReg   <= '0;
      ackSyncReg <= 1'b1;
      dtackReg   <= 1'b1;
      berrReg    <= 1'b1;
    end else begin
      stateReg   <= stateNext;
      regionReg  <= regionNext;
      waitCntReg <= waitCntNext;
      timerReg   <= timerNext;
      ackSyncReg <= ackSyncNext;
      dtackReg   <= dtackNext;
      berrReg    <= berrNext;
    end
  end

  assign DtackOut_L = dtackReg;
  assign BusError_L = berrReg;

endmodule

// File: tb/tb_bus_dtack_generator.sv
// Scoreboard bench for bus_dtack_generator: each bus cycle's expected
// DTACK/BERR edge timing is queued, then compared against what was observed.
module tb_bus_dtack_generator;

  logic clk = 1'b0;
  logic Reset_H, AS_L, UDS_L, LDS_L;
  logic OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H;
  logic DramSelect_H, CanBusSelect_H, OffBoardMemory_H;
  logic DramDtack_L, CanBusDtack_L, OffBoardDtack_L;
  logic DtackOut_L, BusError_L;

  always #5 clk = ~clk;

  bus_dtack_generator dut (
    .Clock             (clk),
    .Reset_H           (Reset_H),
    .AS_L              (AS_L),
    .UDS_L             (UDS_L),
    .LDS_L             (LDS_L),
    .OnChipRomSelect_H (OnChipRomSelect_H),
    .OnChipRamSelect_H (OnChipRamSelect_H),
    .IOSelect_H        (IOSelect_H),
    .DramSelect_H      (DramSelect_H),
    .CanBusSelect_H    (CanBusSelect_H),
    .OffBoardMemory_H  (OffBoardMemory_H),
    .DramDtack_L       (DramDtack_L),
    .CanBusDtack_L     (CanBusDtack_L),
    .OffBoardDtack_L   (OffBoardDtack_L),
    .DtackOut_L        (DtackOut_L),
    .BusError_L        (BusError_L)
  );

  // Edge indices are relative to edge 0 of the cycle; -1 means "never".
  typedef struct {
    string name;
    int    dLow;
    int    dHigh;
    int    bLow;
    int    bHigh;
    int    bothLow;
  } rec_t;

  rec_t expq[$];
  rec_t obsq[$];
  int   compared   = 0;
  int   mismatched = 0;

  localparam logic [5:0] S_ROM  = 6'b000001;
  localparam logic [5:0] S_RAM  = 6'b000010;
  localparam logic [5:0] S_IO   = 6'b000100;
  localparam logic [5:0] S_DRAM = 6'b001000;
  localparam logic [5:0] S_CAN  = 6'b010000;
  localparam logic [5:0] S_OFFB = 6'b100000;

  function automatic void pushExp(input string name, input int dl, input int dh,
                                  input int bl, input int bh);
    rec_t e;
    e.name = name; e.dLow = dl; e.dHigh = dh; e.bLow = bl; e.bHigh = bh; e.bothLow = 0;
    expq.push_back(e);
  endfunction

  task automatic setSelects(input logic [5:0] sel);
    {OffBoardMemory_H, CanBusSelect_H, DramSelect_H,
     IOSelect_H, OnChipRamSelect_H, OnChipRomSelect_H} = sel;
  endtask

  task automatic dropAcks(input logic [5:0] sel);
    if (sel[3]) DramDtack_L = 1'b0;
    if (sel[4]) CanBusDtack_L = 1'b0;
    if (sel[5]) OffBoardDtack_L = 1'b0;
  endtask

  task automatic releaseBus();
    AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
    setSelects(6'b0);
    DramDtack_L = 1'b1; CanBusDtack_L = 1'b1; OffBoardDtack_L = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Called at a negedge; the following posedge is edge 0. Inputs for edge k+1
  // are driven at the negedge after edge k, where outputs of edge k are sampled.
  task automatic runCycle(input string name, input logic [5:0] sel, input logic [1:0] strobesL,
                          input int ackEdge, input int selDropEdge, input int asHighEdge,
                          input int resetEdge, input int maxEdge);
    rec_t o;
    o.name = name; o.dLow = -1; o.dHigh = -1; o.bLow = -1; o.bHigh = -1; o.bothLow = 0;
    setSelects(sel);
    AS_L = 1'b0;
    {UDS_L, LDS_L} = strobesL;
    if (ackEdge == 0) dropAcks(sel);
    for (int k = 0; k <= maxEdge; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (Reset_H) begin
        Reset_H = 1'b0;
        releaseBus();
      end
      if (DtackOut_L === 1'b0 && BusError_L === 1'b0) o.bothLow = 1;
      if (o.dLow < 0 && DtackOut_L !== 1'b1) o.dLow = k;
      else if (o.dLow >= 0 && o.dHigh < 0 && DtackOut_L === 1'b1) o.dHigh = k;
      if (o.bLow < 0 && BusError_L !== 1'b1) o.bLow = k;
      else if (o.bLow >= 0 && o.bHigh < 0 && BusError_L === 1'b1) o.bHigh = k;
      if (k + 1 == ackEdge) dropAcks(sel);
      if (k + 1 == selDropEdge) DramSelect_H = ~DramSelect_H;
      if (k + 1 == asHighEdge) releaseBus();
      if (k + 1 == resetEdge) Reset_H = 1'b1;
    end
    obsq.push_back(o);
  endtask

  task automatic test_reset();
    Reset_H = 1'b1;
    releaseBus();
    idle(2);
    compared++;
    if (DtackOut_L !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_dtack: got %b, expected 1", DtackOut_L);
    end
    compared++;
    if (BusError_L !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_berr: got %b, expected 1", BusError_L);
    end
    $display("txn reset: DtackOut_L=%b BusError_L=%b", DtackOut_L, BusError_L);
    Reset_H = 1'b0;
    idle(2);
  endtask

  task automatic test_fixed_latency();
    rec_t e, o;
    pushExp("ram", 1, 5, -1, -1);
    runCycle("ram", S_RAM, 2'b10, -1, -1, 5, -1, 6);
    idle(2);
    pushExp("io", 3, 6, -1, -1);
    runCycle("io", S_IO, 2'b10, -1, -1, 6, -1, 7);
    idle(2);
    pushExp("rom_io_priority", 2, 4, -1, -1);
    runCycle("rom_io_priority", S_ROM | S_IO, 2'b00, -1, -1, 4, -1, 5);
    idle(2);
    while (obsq.size() > 0 && expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front();
      $display("txn %s: dtack %0d..%0d berr %0d..%0d", o.name, o.dLow, o.dHigh, o.bLow, o.bHigh);
      compared++; if (o.dLow !== e.dLow) begin mismatched++; $display("FAIL %s dtack_low_edge: got %0d, expected %0d", e.name, o.dLow, e.dLow); end
      compared++; if (o.dHigh !== e.dHigh) begin mismatched++; $display("FAIL %s dtack_high_edge: got %0d, expected %0d", e.name, o.dHigh, e.dHigh); end
      compared++; if (o.bLow !== e.bLow) begin mismatched++; $display("FAIL %s berr_low_edge: got %0d, expected %0d", e.name, o.bLow, e.bLow); end
      compared++; if (o.bHigh !== e.bHigh) begin mismatched++; $display("FAIL %s berr_high_edge: got %0d, expected %0d", e.name, o.bHigh, e.bHigh); end
      compared++; if (o.bothLow !== e.bothLow) begin mismatched++; $display("FAIL %s both_low: got %0d, expected %0d", e.name, o.bothLow, e.bothLow); end
    end
  endtask

  task automatic test_external();
    rec_t e, o;
    pushExp("dram_sel_change", 7, 10, -1, -1);
    runCycle("dram_sel_change", S_DRAM, 2'b10, 6, 3, 10, -1, 11);
    idle(2);
    pushExp("can_ack_early", 2, 5, -1, -1);
    runCycle("can_ack_early", S_CAN, 2'b01, 0, -1, 5, -1, 6);
    idle(2);
    pushExp("offboard", 4, 6, -1, -1);
    runCycle("offboard", S_OFFB, 2'b10, 3, -1, 6, -1, 7);
    idle(2);
    while (obsq.size() > 0 && expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front();
      $display("txn %s: dtack %0d..%0d berr %0d..%0d", o.name, o.dLow, o.dHigh, o.bLow, o.bHigh);
      compared++; if (o.dLow !== e.dLow) begin mismatched++; $display("FAIL %s dtack_low_edge: got %0d, expected %0d", e.name, o.dLow, e.dLow); end
      compared++; if (o.dHigh !== e.dHigh) begin mismatched++; $display("FAIL %s dtack_high_edge: got %0d, expected %0d", e.name, o.dHigh, e.dHigh); end
      compared++; if (o.bLow !== e.bLow) begin mismatched++; $display("FAIL %s berr_low_edge: got %0d, expected %0d", e.name, o.bLow, e.bLow); end
      compared++; if (o.bothLow !== e.bothLow) begin mismatched++; $display("FAIL %s both_low: got %0d, expected %0d", e.name, o.bothLow, e.bothLow); end
    end
  endtask

  task automatic test_timeout();
    rec_t e, o;
    pushExp("no_select_timeout", -1, -1, 255, 258);
    runCycle("no_select_timeout", 6'b0, 2'b10, -1, -1, 258, -1, 259);
    idle(2);
    pushExp("ack_vs_timeout", 255, 258, -1, -1);
    runCycle("ack_vs_timeout", S_DRAM, 2'b10, 254, -1, 258, -1, 259);
    idle(2);
    while (obsq.size() > 0 && expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front();
      $display("txn %s: dtack %0d..%0d berr %0d..%0d", o.name, o.dLow, o.dHigh, o.bLow, o.bHigh);
      compared++; if (o.dLow !== e.dLow) begin mismatched++; $display("FAIL %s dtack_low_edge: got %0d, expected %0d", e.name, o.dLow, e.dLow); end
      compared++; if (o.bLow !== e.bLow) begin mismatched++; $display("FAIL %s berr_low_edge: got %0d, expected %0d", e.name, o.bLow, e.bLow); end
      compared++; if (o.bHigh !== e.bHigh) begin mismatched++; $display("FAIL %s berr_high_edge: got %0d, expected %0d", e.name, o.bHigh, e.bHigh); end
      compared++; if (o.bothLow !== e.bothLow) begin mismatched++; $display("FAIL %s both_low: got %0d, expected %0d", e.name, o.bothLow, e.bothLow); end
    end
  endtask

  task automatic test_abort();
    rec_t e, o;
    pushExp("rom_io_abort", -1, -1, -1, -1);
    runCycle("rom_io_abort", S_ROM | S_IO, 2'b10, -1, -1, 1, -1, 3);
    pushExp("ram_after_abort", 1, 3, -1, -1);
    runCycle("ram_after_abort", S_RAM, 2'b10, -1, -1, 3, -1, 4);
    idle(1);
    pushExp("dram_abort", -1, -1, -1, -1);
    runCycle("dram_abort", S_DRAM, 2'b10, -1, -1, 4, -1, 6);
    pushExp("no_strobe", -1, -1, -1, -1);
    runCycle("no_strobe", S_RAM, 2'b11, -1, -1, 3, -1, 4);
    idle(1);
    while (obsq.size() > 0 && expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front();
      $display("txn %s: dtack %0d..%0d berr %0d..%0d", o.name, o.dLow, o.dHigh, o.bLow, o.bHigh);
      compared++; if (o.dLow !== e.dLow) begin mismatched++; $display("FAIL %s dtack_low_edge: got %0d, expected %0d", e.name, o.dLow, e.dLow); end
      compared++; if (o.dHigh !== e.dHigh) begin mismatched++; $display("FAIL %s dtack_high_edge: got %0d, expected %0d", e.name, o.dHigh, e.dHigh); end
      compared++; if (o.bLow !== e.bLow) begin mismatched++; $display("FAIL %s berr_low_edge: got %0d, expected %0d", e.name, o.bLow, e.bLow); end
    end
  endtask

  task automatic test_reset_mid_cycle();
    rec_t e, o;
    pushExp("io_reset", -1, -1, -1, -1);
    runCycle("io_reset", S_IO, 2'b10, -1, -1, -1, 1, 5);
    pushExp("io_after_reset", 3, 5, -1, -1);
    runCycle("io_after_reset", S_IO, 2'b10, -1, -1, 5, -1, 6);
    idle(1);
    pushExp("ram_reset_in_ack", 1, 3, -1, -1);
    runCycle("ram_reset_in_ack", S_RAM, 2'b10, -1, -1, -1, 3, 5);
    idle(1);
    while (obsq.size() > 0 && expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front();
      $display("txn %s: dtack %0d..%0d berr %0d..%0d", o.name, o.dLow, o.dHigh, o.bLow, o.bHigh);
      compared++; if (o.dLow !== e.dLow) begin mismatched++; $display("FAIL %s dtack_low_edge: got %0d, expected %0d", e.name, o.dLow, e.dLow); end
      compared++; if (o.dHigh !== e.dHigh) begin mismatched++; $display("FAIL %s dtack_high_edge: got %0d, expected %0d", e.name, o.dHigh, e.dHigh); end
      compared++; if (o.bLow !== e.bLow) begin mismatched++; $display("FAIL %s berr_low_edge: got %0d, expected %0d", e.name, o.bLow, e.bLow); end
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    pushExp("b2b_ram_1", 1, 3, -1, -1);
    runCycle("b2b_ram_1", S_RAM, 2'b10, -1, -1, 3, -1, 3);
    pushExp("b2b_ram_2", 1, 3, -1, -1);
    runCycle("b2b_ram_2", S_RAM, 2'b10, -1, -1, 3, -1, 3);
    pushExp("b2b_io", 3, 5, -1, -1);
    runCycle("b2b_io", S_IO, 2'b10, -1, -1, 5, -1, 6);
    idle(1);
    while (obsq.size() > 0 && expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front();
      $display("txn %s: dtack %0d..%0d berr %0d..%0d", o.name, o.dLow, o.dHigh, o.bLow, o.bHigh);
      compared++; if (o.dLow !== e.dLow) begin mismatched++; $display("FAIL %s dtack_low_edge: got %0d, expected %0d", e.name, o.dLow, e.dLow); end
      compared++; if (o.dHigh !== e.dHigh) begin mismatched++; $display("FAIL %s dtack_high_edge: got %0d, expected %0d", e.name, o.dHigh, e.dHigh); end
    end
  endtask

  initial begin
    Reset_H = 1'b1;
    releaseBus();
    @(negedge clk);
    test_reset();
    test_fixed_latency();
    test_external();
    test_timeout();
    test_abort();
    test_reset_mid_cycle();
    test_back_to_back();
    compared++;
    if (expq.size() != 0 || obsq.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d/%0d left, expected 0/0", expq.size(), obsq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
